prog_tick_gen: RTL and testbench

- Parametrised, runtime-programmable tick generator; successor to the fixed 1,000,000-cycle tick counter.
- Emits a registered one-cycle `tick` every DIV clocks (continuous mode), or a single `tick` DIV clocks after `start` (one-shot mode).
- Supports enable/pause, synchronous clear, and a safe divisor reload that takes effect at a period boundary.
- Feeds display-refresh, debounce and seconds-timer logic.

---
 rtl/prog_tick_gen.sv | 124 ++++++++++++
 tb/tb_prog_tick_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_tick_gen.sv
// Runtime-programmable tick generator: one-cycle tick every div clocks (continuous)
// or once, div clocks after start (one-shot), with divisor reload at period boundaries.
module prog_tick_gen #(
    parameter int WIDTH       = 20,
    parameter int DEFAULT_DIV = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic             start,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_ld,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             div_err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] div, div_nx;
    logic [WIDTH-1:0] pend_div, pend_div_nx;
    logic             pend_v, pend_v_nx;
    logic             tick_nx, err_nx;
    logic             mode_q;
    logic             apply, wrap;

    // div >= 2 always holds, so div-1 cannot underflow
    assign wrap = (cnt == div - WIDTH'(1));

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        tick_nx     = 1'b0;
        apply       = 1'b0;
        div_nx      = div;
        pend_div_nx = pend_div;
        pend_v_nx   = pend_v;
        err_nx      = 1'b0;

        if (clr || (mode != mode_q)) begin
            cnt_nx   = '0;
            state_nx = IDLE;
            apply    = 1'b1;
        end else if (!en) begin
            apply = mode_q ? (state == IDLE) : (cnt == '0);
        end else if (!mode_q) begin
            if (wrap) begin
                cnt_nx  = '0;
                tick_nx = 1'b1;
                apply   = 1'b1;
            end else begin
                cnt_nx = cnt + WIDTH'(1);
            end
        end else begin
            case (state)
                IDLE: begin
                    apply = 1'b1;
                    // the start edge itself counts as clock 1 of the period
                    if (start) begin
                        state_nx = RUN;
                        cnt_nx   = WIDTH'(1);
                    end
                end
                RUN: begin
                    if (wrap) begin
                        cnt_nx   = '0;
                        tick_nx  = 1'b1;
                        state_nx = IDLE;
                        apply    = 1'b1;
                    end else begin
                        cnt_nx = cnt + WIDTH'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        if (apply && pend_v) begin
            div_nx    = pend_div;
            pend_v_nx = 1'b0;
        end

        // a fresh load on an apply edge stays pending for the next boundary
        if (div_ld) begin
            if (div_in >= WIDTH'(2)) begin
                pend_div_nx = div_in;
                pend_v_nx   = 1'b1;
            end else begin
                err_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            div      <= WIDTH'(DEFAULT_DIV);
            pend_div <= '0;
            pend_v   <= 1'b0;
            tick     <= 1'b0;
            div_err  <= 1'b0;
            mode_q   <= mode;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            div      <= div_nx;
            pend_div <= pend_div_nx;
            pend_v   <= pend_v_nx;
            tick     <= tick_nx;
            div_err  <= err_nx;
            mode_q   <= mode;
        end
    end

    assign count = cnt;
    assign busy  = rst & (mode_q ? (state == RUN) : en);

endmodule

// File: tb/tb_prog_tick_gen.sv
// Directed bench for prog_tick_gen with WIDTH=8, DEFAULT_DIV=5.
module tb_prog_tick_gen;

    logic       clk, rst, en, clr, mode, start, div_ld;
    logic [7:0] div_in;
    logic       tick, busy, div_err;
    logic [7:0] count;
    int         passed, total;

    prog_tick_gen #(.WIDTH(8), .DEFAULT_DIV(5)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .start(start),
        .div_in(div_in), .div_ld(div_ld), .tick(tick), .busy(busy),
        .count(count), .div_err(div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 0; en = 1; clr = 0; mode = 0; start = 0; div_ld = 0; div_in = 0;
        step(); step();
        total++;
        if ({tick, busy, div_err, count} !== 11'h0)
            $display("FAIL reset_state: tick=%b busy=%b div_err=%b count=%0d, want all 0",
                     tick, busy, div_err, count);
        else passed++;
        rst = 1;
    endtask

    // ticks on edges 5, 10, 15; count runs 1,2,3,4,0
    task automatic test_continuous();
        for (int e = 1; e <= 15; e++) begin
            step();
            total++;
            if (count !== 8'(e % 5) || tick !== (e % 5 == 0))
                $display("FAIL cont_e%0d: count=%0d tick=%b, want count=%0d tick=%b",
                         e, count, tick, e % 5, (e % 5 == 0));
            else passed++;
        end
        total++;
        if (busy !== 1'b1) $display("FAIL cont_busy: busy=%b, want 1", busy);
        else passed++;
    endtask

    // rejected load: one-cycle error, spacing stays 5
    task automatic test_div_err();
        div_ld = 1; div_in = 8'd1;
        step();
        div_ld = 0;
        total++;
        if (div_err !== 1'b1 || count !== 8'd1)
            $display("FAIL err_pulse: div_err=%b count=%0d, want 1 and 1", div_err, count);
        else passed++;
        for (int e = 2; e <= 5; e++) begin
            step();
            total++;
            if (div_err !== 1'b0 || tick !== (e == 5) || count !== 8'(e % 5))
                $display("FAIL err_e%0d: div_err=%b tick=%b count=%0d, want 0 %b %0d",
                         e, div_err, tick, count, (e == 5), e % 5);
            else passed++;
        end
    endtask

    task automatic test_pause();
        step(); step(); step();
        total++;
        if (count !== 8'd3) $display("FAIL pause_pre: count=%0d, want 3", count);
        else passed++;
        en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (count !== 8'd3 || tick !== 1'b0 || busy !== 1'b0)
                $display("FAIL pause_hold%0d: count=%0d tick=%b busy=%b, want 3 0 0",
                         i, count, tick, busy);
            else passed++;
        end
        en = 1;
        step();
        total++;
        if (count !== 8'd4 || tick !== 1'b0)
            $display("FAIL pause_r1: count=%0d tick=%b, want 4 0", count, tick);
        else passed++;
        step();
        total++;
        if (count !== 8'd0 || tick !== 1'b1)
            $display("FAIL pause_r2: count=%0d tick=%b, want 0 1", count, tick);
        else passed++;
    endtask

    // load 3 at count=2: current period still 5, then period 3
    task automatic test_reload();
        logic [7:0] ec [9] = '{3, 4, 0, 1, 2, 0, 1, 2, 0};
        logic       et [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
        step(); step();
        div_ld = 1; div_in = 8'd3;
        for (int k = 0; k < 9; k++) begin
            step();
            div_ld = 0;
            total++;
            if (count !== ec[k] || tick !== et[k])
                $display("FAIL reload_k%0d: count=%0d tick=%b, want %0d %b",
                         k, count, tick, ec[k], et[k]);
            else passed++;
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] ec [9] = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        logic       et [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic       eb [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        div_ld = 1; div_in = 8'd5;
        step();
        div_ld = 0; mode = 1;
        step();
        total++;
        if (count !== 8'd0 || busy !== 1'b0 || tick !== 1'b0)
            $display("FAIL os_idle: count=%0d busy=%b tick=%b, want 0 0 0", count, busy, tick);
        else passed++;
        for (int e = 0; e < 9; e++) begin
            start = (e == 0) || (e == 2);
            step();
            start = 0;
            total++;
            if (count !== ec[e] || tick !== et[e] || busy !== eb[e])
                $display("FAIL os_e%0d: count=%0d tick=%b busy=%b, want %0d %b %b",
                         e, count, tick, busy, ec[e], et[e], eb[e]);
            else passed++;
        end
    endtask

    // async reset drops pending divisor 7; periods resume at 5
    task automatic test_async_reset();
        mode = 0;
        step();
        step(); step();
        div_ld = 1; div_in = 8'd7;
        step();
        div_ld = 0;
        total++;
        if (count !== 8'd3) $display("FAIL ar_pre: count=%0d, want 3", count);
        else passed++;
        #3 rst = 0;
        #1;
        total++;
        if ({tick, busy, div_err, count} !== 11'h0)
            $display("FAIL ar_async: tick=%b busy=%b div_err=%b count=%0d, want all 0",
                     tick, busy, div_err, count);
        else passed++;
        step();
        rst = 1;
        for (int e = 1; e <= 10; e++) begin
            step();
            total++;
            if (count !== 8'(e % 5) || tick !== (e % 5 == 0))
                $display("FAIL ar_e%0d: count=%0d tick=%b, want %0d %b",
                         e, count, tick, e % 5, (e % 5 == 0));
            else passed++;
        end
    endtask

    task automatic test_clr_mode();
        step(); step(); step();
        clr = 1;
        step();
        clr = 0;
        total++;
        if (count !== 8'd0 || tick !== 1'b0)
            $display("FAIL clr: count=%0d tick=%b, want 0 0", count, tick);
        else passed++;
        for (int e = 1; e <= 5; e++) begin
            step();
            total++;
            if (count !== 8'(e % 5) || tick !== (e == 5))
                $display("FAIL clr_e%0d: count=%0d tick=%b, want %0d %b",
                         e, count, tick, e % 5, (e == 5));
            else passed++;
        end
        step(); step(); step();
        mode = 1;
        step();
        total++;
        if (count !== 8'd0 || busy !== 1'b0)
            $display("FAIL mode_to1: count=%0d busy=%b, want 0 0", count, busy);
        else passed++;
        mode = 0;
        step();
        total++;
        if (count !== 8'd0 || busy !== 1'b1)
            $display("FAIL mode_to0: count=%0d busy=%b, want 0 1", count, busy);
        else passed++;
        for (int e = 1; e <= 5; e++) begin
            step();
            total++;
            if (count !== 8'(e % 5) || tick !== (e == 5))
                $display("FAIL mode_e%0d: count=%0d tick=%b, want %0d %b",
                         e, count, tick, e % 5, (e == 5));
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_continuous();
        test_div_err();
        test_pause();
        test_reload();
        test_oneshot();
        test_async_reset();
        test_clr_mode();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
